// File: rtl/kat_adc_pkg.sv
// Shared definitions for the KAT ADC sync aligner.
//   align_state_t : sync search / lock FSM states
//   slot_w()      : width of a slot index for a given samples-per-clock count
//   slot_lsb()    : bit offset of (channel, slot) inside a packed sample word
package kat_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

    function automatic int slot_w(input int nspc);
        return (nspc > 1) ? $clog2(nspc) : 1;
    endfunction

    function automatic int slot_lsb(input int ch, input int slot, input int nspc, input int width);
        return (ch * nspc + slot) * width;
    endfunction

endpackage

// File: rtl/kat_adc_slot_rotator.sv
// Combinational slot rotator for one channel.
// Treats {cur, prev} as a 2*NSPC sample stream (prev first, oldest sample
// lowest) and returns the NSPC-sample window starting at slot k of prev.
//   cur     : newest word of the channel
//   prev    : previous valid word of the channel
//   k       : latched sync slot
//   aligned : window with prev[k] in slot 0
module kat_adc_slot_rotator
    import kat_adc_pkg::*;
#(
    parameter int NSPC  = 4,
    parameter int WIDTH = 8
) (
    input  logic [NSPC*WIDTH-1:0]   cur,
    input  logic [NSPC*WIDTH-1:0]   prev,
    input  logic [slot_w(NSPC)-1:0] k,
    output logic [NSPC*WIDTH-1:0]   aligned
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        aligned = '0;
        for (int j = 0; j < NSPC; j++) begin
            if (int'(k) + j < NSPC) begin
                aligned[slot_lsb(0, j, NSPC, WIDTH) +: WIDTH] =
                    prev[slot_lsb(0, int'(k) + j, NSPC, WIDTH) +: WIDTH];
            end else begin
                aligned[slot_lsb(0, j, NSPC, WIDTH) +: WIDTH] =
                    cur[slot_lsb(0, int'(k) + j - NSPC, NSPC, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/kat_adc_sync_aligner.sv
// KAT ADC capture stage: realigns NCH x NSPC samples per clock so the ADC
// sync sample lands in slot 0, checks the sync is periodic (lock / sticky
// error), and keeps saturating per-channel overrange counts.
//   ctrl_clk_in, ctrl_reset_n : clock, async active-low reset
//   in_data/in_sync/in_overrange/in_valid : deserialiser word and flags
//   arm         : pulse, (re)starts the sync search and clears align_err
//   sync_period : expected sync spacing in valid words
//   ovr_clear   : synchronous clear of the overrange counters
//   user_data/user_sync/user_data_valid : realigned output word
//   locked, align_err, sync_slot        : alignment status
//   ovr_count   : per-channel saturating overrange counts
module kat_adc_sync_aligner
    import kat_adc_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int NSPC      = 4,
    parameter int WIDTH     = 8,
    parameter int LOCK_HITS = 4,
    parameter int OVR_W     = 16
) (
    input  logic                        ctrl_clk_in,
    input  logic                        ctrl_reset_n,
    input  logic [NCH*NSPC*WIDTH-1:0]   in_data,
    input  logic [NSPC-1:0]             in_sync,
    input  logic [NCH-1:0]              in_overrange,
    input  logic                        in_valid,
    input  logic                        arm,
    input  logic [31:0]                 sync_period,
    input  logic                        ovr_clear,
    output logic [NCH*NSPC*WIDTH-1:0]   user_data,
    output logic                        user_sync,
    output logic                        user_data_valid,
    output logic                        locked,
    output logic                        align_err,
    output logic [slot_w(NSPC)-1:0]     sync_slot,
    output logic [NCH*OVR_W-1:0]        ovr_count
);

    localparam int SPW = NSPC * WIDTH;
    localparam int DW  = NCH * SPW;
    localparam int KW  = slot_w(NSPC);

    align_state_t    state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [31:0]     cnt, cnt_n;     // valid words since the last accepted sync
    logic [31:0]     hits, hits_n;
    logic            err, err_n;
    logic            tag;            // this word is a matched sync word

    logic [DW-1:0]   prev;
    logic            prev_ok;
    logic            prev_tag;
    logic [DW-1:0]   aligned;

    logic [KW-1:0]   first_slot;
    logic [NSPC-1:0] k_onehot;

    // Lowest set sync bit; search downwards so the lowest index wins.
    always_comb begin
        first_slot = '0;
        for (int s = NSPC - 1; s >= 0; s--) begin
            if (in_sync[s]) first_slot = KW'(s);
        end
    end

    always_comb begin
        k_onehot    = '0;
        k_onehot[k] = 1'b1;
    end

    // Next-state logic. arm is tested first so it beats a simultaneous mismatch.
    always_comb begin
        state_n = state;
        k_n     = k;
        cnt_n   = cnt;
        hits_n  = hits;
        err_n   = err;
        tag     = 1'b0;
        if (arm) begin
            state_n = ST_SEARCH;
            hits_n  = '0;
            err_n   = 1'b0;
        end else if (in_valid) begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_SEARCH: begin
                    if (|in_sync) begin
                        k_n     = first_slot;
                        cnt_n   = 32'd1;
                        hits_n  = '0;
                        tag     = 1'b1;
                        state_n = ST_CHECK;
                    end
                end
                ST_CHECK, ST_LOCKED: begin
                    if (cnt == sync_period) begin
                        if (in_sync == k_onehot) begin
                            tag   = 1'b1;
                            cnt_n = 32'd1;
                            if (state == ST_CHECK) begin
                                hits_n = hits + 32'd1;
                                if (hits_n >= 32'(LOCK_HITS)) state_n = ST_LOCKED;
                            end
                        end else begin
                            err_n   = 1'b1;
                            hits_n  = '0;
                            state_n = ST_SEARCH;
                        end
                    end else if (|in_sync) begin
                        err_n   = 1'b1;
                        hits_n  = '0;
                        state_n = ST_SEARCH;
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state <= ST_IDLE;
            k     <= '0;
            cnt   <= '0;
            hits  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            cnt   <= cnt_n;
            hits  <= hits_n;
            err   <= err_n;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_rot
        kat_adc_slot_rotator #(
            .NSPC  (NSPC),
            .WIDTH (WIDTH)
        ) u_rot (
            .cur     (in_data[c*SPW +: SPW]),
            .prev    (prev[c*SPW +: SPW]),
            .k       (k),
            .aligned (aligned[c*SPW +: SPW])
        );
    end

    // The sync tag travels with its word into prev, so it is emitted together
    // with the output that places that word's slot k in slot 0.
    always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            // NOTE: the prev data register is reset too; it is a single word, not a memory, and a defined value keeps the pipeline deterministic.
            prev            <= '0;
            prev_ok         <= 1'b0;
            prev_tag        <= 1'b0;
            user_data       <= '0;
            user_sync       <= 1'b0;
            user_data_valid <= 1'b0;
        end else begin
            user_data_valid <= in_valid & prev_ok;
            if (in_valid) begin
                prev     <= in_data;
                prev_ok  <= 1'b1;
                prev_tag <= tag;
            end
            if (in_valid && prev_ok) begin
                user_data <= aligned;
                user_sync <= prev_tag;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ovr
        logic [OVR_W-1:0] ovr_q;

        always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
            if (!ctrl_reset_n) begin
                ovr_q <= '0;
            end else if (ovr_clear) begin
                ovr_q <= '0;
            end else if (in_valid && in_overrange[c] && (ovr_q != '1)) begin
                ovr_q <= ovr_q + OVR_W'(1);
            end
        end

        assign ovr_count[c*OVR_W +: OVR_W] = ovr_q;
    end

    assign locked    = (state == ST_LOCKED);
    assign align_err = err;
    assign sync_slot = k;

endmodule

// File: tb/tb_kat_adc_sync_aligner.sv
// Self-checking bench for kat_adc_sync_aligner: a behavioural model predicts
// each realigned word into a scoreboard queue; a monitor pops and compares
// whenever the DUT presents user_data_valid.
module tb_kat_adc_sync_aligner;
    import kat_adc_pkg::*;

    localparam int NCH       = 2;
    localparam int NSPC      = 4;
    localparam int WIDTH     = 8;
    localparam int LOCK_HITS = 4;
    localparam int OVR_W     = 16;
    localparam int DW        = NCH * NSPC * WIDTH;
    localparam int KW        = slot_w(NSPC);
    localparam int PERIOD    = 8;
    localparam int unsigned OVR_MAX = (1 << OVR_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_SEARCH = 1;
    localparam int M_CHECK  = 2;
    localparam int M_LOCKED = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [DW-1:0]        in_data = '0;
    logic [NSPC-1:0]      in_sync = '0;
    logic [NCH-1:0]       in_overrange = '0;
    logic                 in_valid = 1'b0;
    logic                 arm = 1'b0;
    logic [31:0]          sync_period = 32'(PERIOD);
    logic                 ovr_clear = 1'b0;
    logic [DW-1:0]        user_data;
    logic                 user_sync;
    logic                 user_data_valid;
    logic                 locked;
    logic                 align_err;
    logic [KW-1:0]        sync_slot;
    logic [NCH*OVR_W-1:0] ovr_count;

    always #5 clk = ~clk;

    kat_adc_sync_aligner #(
        .NCH       (NCH),
        .NSPC      (NSPC),
        .WIDTH     (WIDTH),
        .LOCK_HITS (LOCK_HITS),
        .OVR_W     (OVR_W)
    ) dut (
        .ctrl_clk_in     (clk),
        .ctrl_reset_n    (rst_n),
        .in_data         (in_data),
        .in_sync         (in_sync),
        .in_overrange    (in_overrange),
        .in_valid        (in_valid),
        .arm             (arm),
        .sync_period     (sync_period),
        .ovr_clear       (ovr_clear),
        .user_data       (user_data),
        .user_sync       (user_sync),
        .user_data_valid (user_data_valid),
        .locked          (locked),
        .align_err       (align_err),
        .sync_slot       (sync_slot),
        .ovr_count       (ovr_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            sync;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   g_idx    = 0;

    // Reference model state
    int          m_mode;
    int          m_k;
    int          m_since;   // valid words since the last accepted sync
    int          m_hits;
    bit          m_err;
    bit          m_have_prev;
    logic [DW-1:0] m_prev;
    bit          m_prev_tag;
    int unsigned m_ovr[NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // View prev and cur as one sample stream per channel; output is the
    // NSPC-sample window starting at stream position k.
    function automatic logic [DW-1:0] window(input logic [DW-1:0] p, input logic [DW-1:0] c, input int k);
        logic [WIDTH-1:0] stream_s[2*NSPC];
        logic [DW-1:0]    r;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int i = 0; i < NSPC; i++) begin
                stream_s[i]        = p[(ch*NSPC + i)*WIDTH +: WIDTH];
                stream_s[NSPC + i] = c[(ch*NSPC + i)*WIDTH +: WIDTH];
            end
            for (int j = 0; j < NSPC; j++) r[(ch*NSPC + j)*WIDTH +: WIDTH] = stream_s[k + j];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < NCH*NSPC; i++) w[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_k = 0; m_since = 0; m_hits = 0; m_err = 0;
        m_have_prev = 0; m_prev = '0; m_prev_tag = 0;
        for (int c = 0; c < NCH; c++) m_ovr[c] = 0;
    endtask

    task automatic model_mismatch();
        m_err = 1; m_mode = M_SEARCH; m_hits = 0;
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] d, input logic [NSPC-1:0] s,
                              input logic [NCH-1:0] o, input bit a, input bit clr);
        bit tag;
        exp_t e;
        tag = 0;
        for (int c = 0; c < NCH; c++) begin
            if (clr) m_ovr[c] = 0;
            else if (v && o[c] && m_ovr[c] < OVR_MAX) m_ovr[c]++;
        end
        if (v && m_have_prev) begin
            e.data = window(m_prev, d, m_k);
            e.sync = m_prev_tag;
            sb.push_back(e);
        end
        if (a) begin
            m_mode = M_SEARCH; m_err = 0; m_hits = 0;
        end else if (v) begin
            if (m_mode == M_SEARCH) begin
                if (s != 0) begin
                    for (int i = NSPC - 1; i >= 0; i--) if (s[i]) m_k = i;
                    m_since = 0; m_hits = 0; tag = 1; m_mode = M_CHECK;
                end
            end else if (m_mode == M_CHECK || m_mode == M_LOCKED) begin
                m_since++;
                if (m_since == PERIOD) begin
                    if (int'(s) == (1 << m_k)) begin
                        tag = 1; m_since = 0;
                        if (m_mode == M_CHECK) begin
                            m_hits++;
                            if (m_hits == LOCK_HITS) m_mode = M_LOCKED;
                        end
                    end else begin
                        model_mismatch();
                    end
                end else if (s != 0) begin
                    model_mismatch();
                end
            end
        end
        if (v) begin
            m_prev = d; m_have_prev = 1; m_prev_tag = tag;
        end
    endtask

    task automatic send(input bit v, input logic [DW-1:0] d, input logic [NSPC-1:0] s,
                        input logic [NCH-1:0] o, input bit a, input bit clr);
        @(negedge clk);
        in_valid = v; in_data = d; in_sync = s; in_overrange = o; arm = a; ovr_clear = clr;
        model_step(v, d, s, o, a, clr);
        @(posedge clk);
        #1;
        check("locked", 64'(locked), 64'(m_mode == M_LOCKED));
        check("align_err", 64'(align_err), 64'(m_err));
        check("sync_slot", 64'(sync_slot), 64'(m_k));
        for (int c = 0; c < NCH; c++) check("ovr_count", 64'(ovr_count[c*OVR_W +: OVR_W]), 64'(m_ovr[c]));
    endtask

    // Periodic sync stream indexed by the global valid-word counter g_idx.
    task automatic stream(input int n, input int slot, input int first, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic [NSPC-1:0] s;
            if (gaps) send(1'b0, '0, '0, '0, 1'b0, 1'b0);
            s = (g_idx >= first && (g_idx - first) % PERIOD == 0) ? NSPC'(1 << slot) : '0;
            send(1'b1, rand_word(), s, '0, 1'b0, 1'b0);
            g_idx++;
        end
    endtask

    task automatic check_reset(input string tag_s);
        check({tag_s, "_user_data"}, 64'(user_data), 64'd0);
        check({tag_s, "_user_sync"}, 64'(user_sync), 64'd0);
        check({tag_s, "_user_data_valid"}, 64'(user_data_valid), 64'd0);
        check({tag_s, "_locked"}, 64'(locked), 64'd0);
        check({tag_s, "_align_err"}, 64'(align_err), 64'd0);
        check({tag_s, "_sync_slot"}, 64'(sync_slot), 64'd0);
        check({tag_s, "_ovr_count"}, 64'(ovr_count), 64'd0);
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (user_data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_user_data_valid", 64'(user_data_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("user_data", 64'(user_data), 64'(e.data));
                    check("user_sync", 64'(user_sync), 64'(e.sync));
                end
            end else if (sb.size() != 0) begin
                check("missing_user_data_valid", 64'(user_data_valid), 64'd1);
                sb.delete();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Unarmed: plain one-word delay, k stays 0
        for (int i = 0; i < 3; i++) send(1'b1, rand_word(), NSPC'($urandom), NCH'($urandom), 1'b0, 1'b0);
        check("t1_sync_slot", 64'(sync_slot), 64'd0);
        check("t1_locked", 64'(locked), 64'd0);

        // Lock on slot 2
        send(1'b0, '0, '0, '0, 1'b1, 1'b0);
        g_idx = 0;
        stream(35, 2, 3, 1'b0);
        check("t2_locked_before_4th", 64'(locked), 64'd0);
        stream(1, 2, 3, 1'b0);
        check("t2_locked", 64'(locked), 64'd1);
        check("t2_sync_slot", 64'(sync_slot), 64'd2);

        // Sync moves to slot 1: error, then relock at k = 1
        stream(8, 1, 3, 1'b0);
        check("t3_align_err", 64'(align_err), 64'd1);
        check("t3_locked_dropped", 64'(locked), 64'd0);
        stream(40, 1, 3, 1'b0);
        check("t3_relocked", 64'(locked), 64'd1);
        check("t3_sync_slot", 64'(sync_slot), 64'd1);
        check("t3_err_sticky", 64'(align_err), 64'd1);
        send(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check("t3_err_cleared", 64'(align_err), 64'd0);

        // Alternate in_valid every other cycle
        stream(47, 1, 3, 1'b1);
        check("t4_locked", 64'(locked), 64'd1);
        stream(16, 1, 3, 1'b1);
        check("t4_still_locked", 64'(locked), 64'd1);
        check("t4_no_err", 64'(align_err), 64'd0);

        // Randomized traffic with corrupted syncs, arms and clears
        send(1'b0, '0, '0, '0, 1'b1, 1'b0);
        begin
            int first;
            first = g_idx + 1;
            for (int i = 0; i < 400; i++) begin
                bit v;
                logic [NSPC-1:0] s;
                v = ($urandom_range(0, 9) < 7);
                s = (g_idx >= first && (g_idx - first) % PERIOD == 0) ? NSPC'(1 << 2) : '0;
                if ($urandom_range(0, 99) < 4) s = NSPC'($urandom_range(1, (1 << NSPC) - 1));
                send(v, rand_word(), v ? s : '0, NCH'($urandom), ($urandom_range(0, 99) < 2),
                     ($urandom_range(0, 99) < 3));
                if (v) g_idx++;
            end
        end

        // Overrange saturation
        send(1'b0, '0, '0, '0, 1'b1, 1'b1);
        check("t6_cleared", 64'(ovr_count), 64'd0);
        for (int i = 0; i < 70000; i++) send(1'b1, rand_word(), '0, NCH'(1), 1'b0, 1'b0);
        check("t6_ch0_sat", 64'(ovr_count[0 +: OVR_W]), 64'd65535);
        check("t6_ch1_zero", 64'(ovr_count[OVR_W +: OVR_W]), 64'd0);
        send(1'b1, rand_word(), '0, NCH'(3), 1'b0, 1'b1);
        check("t6_clear_wins", 64'(ovr_count), 64'd0);

        // Async reset mid-CHECK
        send(1'b0, '0, '0, '0, 1'b1, 1'b0);
        g_idx = 0;
        stream(20, 3, 2, 1'b0);
        check("t7_sync_slot", 64'(sync_slot), 64'd3);
        check("t7_in_check", 64'(locked), 64'd0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; arm = 1'b0; ovr_clear = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        g_idx = 0;
        stream(20, 3, 2, 1'b0);
        check("t7_no_search_locked", 64'(locked), 64'd0);
        check("t7_no_search_slot", 64'(sync_slot), 64'd0);
        send(1'b0, '0, '0, '0, 1'b0, 1'b0);
        send(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #3;
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
